// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller for an external bank of WIDTH JK flip-flops.
// Accepts one command per valid/ready handshake and drives per-bit J/K lines,
// using the bank's Q outputs as feedback for clear/set/load/toggle/count/rotate.
// Optional build macro JK_SAT_EN: UP/DOWN hold at all-ones/zero instead of wrapping.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'b000,
    OP_CLEAR  = 3'b001,
    OP_SET    = 3'b010,
    OP_LOAD   = 3'b011,
    OP_TOGGLE = 3'b100,
    OP_UP     = 3'b101,
    OP_DOWN   = 3'b110,
    OP_ROTL   = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] rot;
  logic             hold_c;

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state, command latch and remaining-step bookkeeping
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d   = op_t'(cmd_op);
          data_d = cmd_data;
          unique case (op_t'(cmd_op))
            OP_NOP: begin
              rem_d   = CNT_W'(0);
              state_d = ST_DONE;
            end
            OP_CLEAR, OP_SET, OP_LOAD, OP_TOGGLE: begin
              rem_d   = CNT_W'(1);
              state_d = ST_EXEC;
            end
            default: begin
              rem_d   = cmd_count;
              state_d = (cmd_count == CNT_W'(0)) ? ST_DONE : ST_EXEC;
            end
          endcase
        end
      end
      ST_EXEC: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, latched command and registered status outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Per-bit toggle enables for counting: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      up_t[i] = up_t[i-1] & Q[i-1];
      dn_t[i] = dn_t[i-1] & ~Q[i-1];
    end
    rot = {Q[WIDTH-2:0], Q[WIDTH-1]};
  end

  // Saturation hold at the count limits (only in the saturating build)
  always_comb begin
    hold_c = 1'b0;
`ifdef JK_SAT_EN
    if ((op_q == OP_UP) && (&Q)) begin
      hold_c = 1'b1;
    end
    if ((op_q == OP_DOWN) && (~|Q)) begin
      hold_c = 1'b1;
    end
`else
    hold_c = 1'b0;
`endif
  end

  // J/K drive: live from latched op/data and current Q while executing, idle low otherwise
  always_comb begin
    J = '0;
    K = '0;
    if ((state_q == ST_EXEC) && !hold_c) begin
      unique case (op_q)
        OP_CLEAR: begin
          J = '0;
          K = '1;
        end
        OP_SET: begin
          J = '1;
          K = '0;
        end
        OP_LOAD: begin
          J = data_q;
          K = ~data_q;
        end
        OP_TOGGLE: begin
          J = data_q;
          K = data_q;
        end
        OP_UP: begin
          J = up_t;
          K = up_t;
        end
        OP_DOWN: begin
          J = dn_t;
          K = dn_t;
        end
        OP_ROTL: begin
          J = rot;
          K = ~rot;
        end
        default: begin
          J = '0;
          K = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: behavioural JK bank in the loop, expected bank
// states queued at issue time and popped at each executing edge.
module tb_jk_bank_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             Clk;
  logic             Rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] q_bank;
  logic             preset_en;
  logic [WIDTH-1:0] preset_val;
  int               done_total;
  int               chk_cnt;
  int               pass_cnt;
  int               fail_cnt;
  logic [WIDTH-1:0] exp_q[$];

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .Q         (Q),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done)
  );

  assign Q = q_bank;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural JK bank (no reset of its own; preset used to set start values)
  always @(posedge Clk) begin
    if (preset_en) begin
      q_bank <= preset_val;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        case ({J[i], K[i]})
          2'b10:   q_bank[i] <= 1'b1;
          2'b01:   q_bank[i] <= 1'b0;
          2'b11:   q_bank[i] <= ~q_bank[i];
          default: q_bank[i] <= q_bank[i];
        endcase
      end
    end
  end

  // Count done pulses (value seen at each rising edge)
  always @(posedge Clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    @(negedge Clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge Clk);
    preset_en  = 1'b0;
  endtask

  // Present a command and return #1 after the handshake edge
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] cnt, input bit hold);
    int n;
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      check("handshake_timeout", 32'(cmd_ready), 32'd1);
    end
    @(posedge Clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Follow a command to completion: pop one expected bank value per executing edge
  task automatic drain(input string tag, input int exp_busy);
    int  busy_cyc;
    int  d0;
    bit  fin;
    busy_cyc = 0;
    fin      = 1'b0;
    d0       = done_total;
    for (int n = 0; n < 300 && !fin; n++) begin
      if (busy === 1'b1) busy_cyc++;
      check({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
      if (done === 1'b1) begin
        check({tag, "_j_done"}, 32'(J), 32'd0);
        check({tag, "_k_done"}, 32'(K), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        fin = 1'b1;
      end else begin
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) check({tag, "_q"}, 32'(q_bank), 32'(exp_q.pop_front()));
        else check({tag, "_extra_exec"}, 32'd1, 32'd0);
      end
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    @(posedge Clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_total - d0), 32'd1);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done_low_after"}, 32'(done), 32'd0);
    check({tag, "_busy_low_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    chk_cnt    = 0;
    pass_cnt   = 0;
    fail_cnt   = 0;
    done_total = 0;
    preset_en  = 1'b0;
    preset_val = '0;
    q_bank     = '0;
    cmd_valid  = 1'b0;
    cmd_op     = 3'b000;
    cmd_data   = '0;
    cmd_count  = '0;
    Rst        = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rst_j", 32'(J), 32'd0);
    check("rst_k", 32'(K), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Reset pulse in the middle of idle
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("idle_rst_j", 32'(J), 32'd0);
    check("idle_rst_done", 32'(done), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("idle_rst_ready", 32'(cmd_ready), 32'd1);

    // LOAD 1010
    preset(4'b0000);
    exp_q.push_back(4'b1010);
    issue(3'b011, 4'b1010, 8'd0, 1'b0);
    drain("load", 2);

    // SET, CLEAR, NOP
    exp_q.push_back(4'b1111);
    issue(3'b010, 4'b0000, 8'd0, 1'b0);
    drain("set", 2);
    exp_q.push_back(4'b0000);
    issue(3'b001, 4'b0000, 8'd0, 1'b0);
    drain("clear", 2);
    preset(4'b0110);
    issue(3'b000, 4'b1111, 8'd9, 1'b0);
    drain("nop", 1);
    check("nop_q_unchanged", 32'(q_bank), 32'h6);

    // UP x5 from 0011
    preset(4'b0011);
    for (int v = 4; v <= 8; v++) exp_q.push_back(4'(v));
    issue(3'b101, 4'b0000, 8'd5, 1'b0);
    drain("up5", 6);

    // UP x3 from 1110: wrap or saturate
    preset(4'b1110);
`ifdef JK_SAT_EN
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
`else
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
`endif
    issue(3'b101, 4'b0000, 8'd3, 1'b0);
    drain("up_limit", 4);

    // DOWN x2 from 0001: wrap or saturate at zero
    preset(4'b0001);
    exp_q.push_back(4'b0000);
`ifdef JK_SAT_EN
    exp_q.push_back(4'b0000);
`else
    exp_q.push_back(4'b1111);
`endif
    issue(3'b110, 4'b0000, 8'd2, 1'b0);
    drain("down_limit", 3);

    // ROTL 1001 -> 0011, TOGGLE 0110 -> 0101, DOWN count 0
    preset(4'b1001);
    exp_q.push_back(4'b0011);
    issue(3'b111, 4'b0000, 8'd1, 1'b0);
    drain("rotl", 2);
    exp_q.push_back(4'b0101);
    issue(3'b100, 4'b0110, 8'd0, 1'b0);
    drain("toggle", 2);
    issue(3'b110, 4'b0000, 8'd0, 1'b0);
    drain("down0", 1);
    check("down0_q", 32'(q_bank), 32'h5);

    // cmd_valid held through a 4-step UP; LOAD queued behind it
    preset(4'b0000);
    for (int v = 1; v <= 4; v++) exp_q.push_back(4'(v));
    issue(3'b101, 4'b0000, 8'd4, 1'b1);
    cmd_op   = 3'b011;
    cmd_data = 4'b0110;
    drain("hs_up4", 5);
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    check("hs_second_accepted", 32'(busy), 32'd1);
    exp_q.push_back(4'b0110);
    drain("hs_load", 2);

    // Reset mid-EXEC: DOWN x8 from 1000, reset during the fourth step
    preset(4'b1000);
    d0 = done_total;
    issue(3'b110, 4'b0000, 8'd8, 1'b0);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0101);
    for (int s = 0; s < 3; s++) begin
      @(posedge Clk);
      #1;
      check("rstop_q", 32'(q_bank), 32'(exp_q.pop_front()));
    end
    Rst = 1'b1;
    #1;
    check("rstop_j", 32'(J), 32'd0);
    check("rstop_k", 32'(K), 32'd0);
    check("rstop_busy", 32'(busy), 32'd0);
    check("rstop_done", 32'(done), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    check("rstop_q_held", 32'(q_bank), 32'h5);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rstop_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge Clk);
    #1;
    check("rstop_no_done", 32'(done_total - d0), 32'd0);
    check("rstop_q_final", 32'(q_bank), 32'h5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller that sequences an external bank of WIDTH JK flip-flops.
- Accepts commands over a valid/ready handshake and drives per-bit J/K lines for the required number of cycles.
- Uses the bank's Q outputs as feedback to perform clear, set, load, toggle, up/down count and rotate.
- Sits between a lab-level command source (switch/FSM front end) and the JK register bank.

Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank (2..16).
- CNT_W, 8, width of the repeat-count field.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (IDLE only).
- cmd_op  input  3  opcode: 000 NOP, 001 CLEAR, 010 SET, 011 LOAD, 100 TOGGLE, 101 UP, 110 DOWN, 111 ROTL.
- cmd_data  input  WIDTH  load value (LOAD) or toggle mask (TOGGLE); ignored otherwise.
- cmd_count  input  CNT_W  step count for UP/DOWN/ROTL; ignored otherwise.
- Q  input  WIDTH  feedback from the JK bank.
- J  output  WIDTH  J lines to the bank.
- K  output  WIDTH  K lines to the bank.
- busy  output  1  high in EXEC or DONE.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE, J=K=0, done=0, busy=0, cmd_ready=1 once Rst deasserts.
  - Latched op, data and remaining-count registers cleared.
  - Bank contents are not touched by the controller; the bank's own reset is handled at integration.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1, J=K=0. Handshake = cmd_valid&cmd_ready at a rising edge. Latch op/data/count on handshake.
  - Next state after handshake:
    - NOP -> DONE.
    - CLEAR/SET/LOAD/TOGGLE -> EXEC with remaining=1.
    - UP/DOWN/ROTL -> EXEC with remaining=cmd_count; if cmd_count=0 -> DONE directly.
  - EXEC: cmd_ready=0; J/K driven combinationally from latched op, data and current Q. The bank updates at the edge closing each EXEC cycle; remaining decrements on that edge. When remaining==1 at the edge -> DONE.
  - DONE: done=1 for exactly one cycle, J=K=0, -> IDLE.
- J/K encoding per bit i:
  - CLEAR: J=0, K=1.
  - SET: J=1, K=0.
  - LOAD: J=data[i], K=~data[i].
  - TOGGLE: J=K=data[i].
  - UP: J=K=AND(Q[i-1:0]); bit0 always J=K=1.
  - DOWN: J=K=AND(~Q[i-1:0]); bit0 always J=K=1.
  - ROTL: J=Q[i-1], K=~Q[i-1], with index i-1 taken modulo WIDTH (bit0 takes Q[WIDTH-1]).
- Timing:
  - Latency from handshake edge to first bank update: 1 cycle.
  - Command of N steps occupies N EXEC cycles plus 1 DONE cycle.
  - Next cmd_ready rises the cycle after done.
- Counting wraps modulo 2^WIDTH unless JK_SAT_EN is defined.
- cmd_valid while busy is ignored; the source holds it until cmd_ready.
- Reset mid-EXEC:
  - J/K drop to 0 immediately (async) and no done pulse is issued.
  - Bank keeps its partially updated value.

Optional Feature:
- Macro: JK_SAT_EN.
- Defined: UP at Q=all-ones and DOWN at Q=0 drive J=K=0 (hold). Remaining still decrements and done still fires after N cycles.
- Undefined: UP/DOWN wrap (1111->0000, 0000->1111).

Test Plan:
- Reset: Rst pulsed mid-idle -> J=K=0, cmd_ready=1, done=0. Then LOAD data=1010 -> Q=1010 after 1 EXEC cycle; done pulses at the next cycle.
- Count: Q=0011, UP count=5 -> Q steps 0100,0101,0110,0111,1000 on consecutive edges. busy high for 6 cycles, single done pulse.
- Wrap/sat: Q=1110, UP count=3 -> wraps to 0001 without the macro; stays 1111 with JK_SAT_EN. done fires after 3 EXEC cycles in both builds.
- Rotate/toggle: Q=1001, ROTL count=1 -> 0011. Then TOGGLE mask=0110 -> 0101. Then DOWN count=0 -> straight to DONE with Q unchanged.
- Handshake: cmd_valid held through a busy 4-step command -> second command accepted only on the cycle after done. No J/K activity during DONE.
- Reset mid-op: DOWN count=8 from 1000, Rst asserted after 3 EXEC cycles -> Q=0101 held, J=K=0 immediately, no done pulse, IDLE after release.
